// File: rtl/wide_add_seq_pkg.sv
// Shared constants and types for the multi-word add/subtract sequencer.
package wide_add_seq_pkg;

    localparam int WORD_W     = 32;
    localparam int NWORDS_MAX = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word counter width; a single-word operation still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wide_add_seq_adder32.sv
// Purely combinational 32-bit adder with carry in/out, shared by the sequencer.
module adder32
    import wide_add_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              cout
);

    logic [WORD_W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};
    assign s        = full_sum[WORD_W-1:0];
    assign cout     = full_sum[WORD_W];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-word add/subtract: one 32-bit adder, carry chained through a register,
// one operand word pair per cycle, LSW first, results streamed with valid/ready.
module wide_add_seq
    import wide_add_seq_pkg::*;
#(
    parameter int NWORDS = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic              cmd_sub,
    output logic              cmd_ready,
    input  logic              op_valid,
    input  logic [WORD_W-1:0] op_a,
    input  logic [WORD_W-1:0] op_b,
    output logic              op_ready,
    output logic              res_valid,
    output logic [WORD_W-1:0] res_s,
    output logic              res_last,
    output logic              res_cout,
    output logic              res_ovf,
    input  logic              res_ready,
    output logic              busy
);

    localparam int                IDX_W    = idx_width(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                sub_q, sub_d;
    logic                res_valid_q, res_valid_d;
    logic [WORD_W-1:0]   res_s_q, res_s_d;
    logic                res_last_q, res_last_d;
    logic                res_cout_q, res_cout_d;
    logic                res_ovf_q, res_ovf_d;

    logic                cmd_acc, op_acc, is_last;
    logic [WORD_W-1:0]   b_eff, sum;
    logic                add_cout, ovf;

    // Subtraction is A + ~B + 1: the +1 comes from carry_q being preset at command accept.
    assign b_eff = sub_q ? ~op_b : op_b;

    adder32 u_adder (
        .a    (op_a),
        .b    (b_eff),
        .cin  (carry_q),
        .s    (sum),
        .cout (add_cout)
    );

    assign cmd_acc = cmd_valid & cmd_ready;
    assign op_acc  = op_valid & op_ready;
    assign is_last = (idx_q == LAST_IDX);
    assign ovf     = (op_a[WORD_W-1] == b_eff[WORD_W-1]) & (sum[WORD_W-1] != op_a[WORD_W-1]);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_s_q     <= '0;
            res_last_q  <= 1'b0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            res_valid_q <= res_valid_d;
            res_s_q     <= res_s_d;
            res_last_q  <= res_last_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_acc) state_d = ST_RUN;
            ST_RUN:  if (op_acc && is_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        op_ready  = (state_q == ST_RUN) && (!res_valid_q || res_ready);
        busy      = (state_q == ST_RUN) || res_valid_q;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        idx_d       = idx_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        res_valid_d = res_valid_q;
        res_s_d     = res_s_q;
        res_last_d  = res_last_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;

        if (cmd_acc) begin
            sub_d   = cmd_sub;
            carry_d = cmd_sub;
            idx_d   = '0;
        end

        // op_acc implies the previous word transfers or was absent, so the result
        // registers only change when they are free to change.
        if (op_acc) begin
            res_s_d     = sum;
            carry_d     = add_cout;
            res_valid_d = 1'b1;
            res_last_d  = is_last;
            res_cout_d  = is_last & add_cout;
            res_ovf_d   = is_last & ovf;
            idx_d       = is_last ? '0 : idx_q + 1'b1;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_s     = res_s_q;
    assign res_last  = res_last_q;
    assign res_cout  = res_cout_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq with NWORDS = 4.
module tb_wide_add_seq;

    typedef logic [3:0][31:0] vec_t;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_sub, cmd_ready;
    logic        op_valid, op_ready;
    logic [31:0] op_a, op_b, res_s;
    logic        res_valid, res_last, res_cout, res_ovf, res_ready, busy;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t a1, b1, s1, a2, b2, s2;

    wide_add_seq #(.NWORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_sub   (cmd_sub),
        .cmd_ready (cmd_ready),
        .op_valid  (op_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_s     (res_s),
        .res_last  (res_last),
        .res_cout  (res_cout),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One full command with res_ready high throughout.
    task automatic run_op(input string tag, input logic sub, input vec_t a, input vec_t b,
                          input vec_t s, input logic exp_cout, input logic exp_ovf);
        cmd_valid = 1'b1;
        cmd_sub   = sub;
        step();
        cmd_valid = 1'b0;
        check({tag, "_cmd_ready_run"}, cmd_ready, 1'b0);
        check({tag, "_busy_run"}, busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            op_valid = 1'b1;
            op_a     = a[i];
            op_b     = b[i];
            step();
            check($sformatf("%s_valid%0d", tag, i), res_valid, 1'b1);
            check($sformatf("%s_s%0d", tag, i), res_s, s[i]);
            check($sformatf("%s_last%0d", tag, i), res_last, (i == 3));
        end
        op_valid = 1'b0;
        check({tag, "_cout"}, res_cout, exp_cout);
        check({tag, "_ovf"}, res_ovf, exp_ovf);
        check({tag, "_cmd_ready_done"}, cmd_ready, 1'b1);
        step();
        check({tag, "_valid_clear"}, res_valid, 1'b0);
        check({tag, "_busy_clear"}, busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_sub = 1'b0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b1;
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_op_ready", op_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_s", res_s, 32'h0);
        check("rst_res_last", res_last, 1'b0);
        check("rst_res_cout", res_cout, 1'b0);
        check("rst_res_ovf", res_ovf, 1'b0);
        rst = 1'b0;

        // Vectors are written MSW first; index 0 is the first beat.
        run_op("add128", 1'b0, {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF},
               {32'h0, 32'h0, 32'h0, 32'h1}, {32'h0, 32'h1, 32'h0, 32'h0}, 1'b0, 1'b0);
        run_op("sub_borrow", 1'b1, {32'h0, 32'h0, 32'h0, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h1},
               {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 1'b0, 1'b0);
        run_op("sub_equal", 1'b1, {32'h0, 32'h0, 32'h0, 32'h5},
               {32'h0, 32'h0, 32'h0, 32'h5}, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b0);
        run_op("add_ovf", 1'b0, {32'h7FFFFFFF, 32'h0, 32'h0, 32'h0},
               {32'h00000001, 32'h0, 32'h0, 32'h0}, {32'h80000000, 32'h0, 32'h0, 32'h0}, 1'b0, 1'b1);
        run_op("sub_ovf", 1'b1, {32'h80000000, 32'h0, 32'h0, 32'h0},
               {32'h00000001, 32'h0, 32'h0, 32'h0}, {32'h7FFFFFFF, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b1);

        // Backpressure: result word 0 stalls for three cycles.
        cmd_valid = 1'b1; cmd_sub = 1'b0;
        step();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 32'hFFFFFFFF; op_b = 32'h2;
        step();
        check("bp_valid0", res_valid, 1'b1);
        check("bp_s0", res_s, 32'h1);
        res_ready = 1'b0; op_a = 32'h10; op_b = 32'h20;
        #1;
        check("bp_op_ready_low", op_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bp_stall_op_ready%0d", i), op_ready, 1'b0);
            check($sformatf("bp_stall_valid%0d", i), res_valid, 1'b1);
            check($sformatf("bp_stall_s%0d", i), res_s, 32'h1);
            check($sformatf("bp_stall_last%0d", i), res_last, 1'b0);
        end
        res_ready = 1'b1;
        #1;
        check("bp_op_ready_release", op_ready, 1'b1);
        step();
        check("bp_s1", res_s, 32'h31);
        op_a = 32'hFFFFFFFF; op_b = 32'h1;
        step();
        check("bp_s2", res_s, 32'h0);
        check("bp_last2", res_last, 1'b0);
        op_a = 32'h7FFFFFFF; op_b = 32'h80000000;
        step();
        op_valid = 1'b0;
        check("bp_s3", res_s, 32'h0);
        check("bp_last3", res_last, 1'b1);
        check("bp_cout", res_cout, 1'b1);
        check("bp_ovf", res_ovf, 1'b0);
        step();
        check("bp_valid_clear", res_valid, 1'b0);

        // Reset after two of four beats.
        cmd_valid = 1'b1; cmd_sub = 1'b0;
        step();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 32'hFFFFFFFF; op_b = 32'h1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; op_valid = 1'b0;
        check("mid_rst_res_valid", res_valid, 1'b0);
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_res_s", res_s, 32'h0);
        check("mid_rst_op_ready", op_ready, 1'b0);
        run_op("post_rst_sub", 1'b1, {32'h0, 32'h0, 32'h0, 32'h0},
               {32'h0, 32'h0, 32'h0, 32'h1},
               {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 1'b0, 1'b0);

        // Back-to-back: cmd_valid, op_valid, res_ready all held high.
        a1 = {32'h4, 32'h3, 32'h2, 32'h1};
        b1 = {32'h8, 32'h7, 32'h6, 32'h5};
        s1 = {32'hC, 32'hA, 32'h8, 32'h6};
        a2 = {32'h40, 32'h30, 32'h20, 32'h10};
        b2 = {32'h4, 32'h3, 32'h2, 32'h1};
        s2 = {32'h3C, 32'h2D, 32'h1E, 32'hF};
        cmd_valid = 1'b1; cmd_sub = 1'b0; op_valid = 1'b1; op_a = a1[0]; op_b = b1[0];
        step();
        check("b2b_cmd1_taken", cmd_ready, 1'b0);
        check("b2b_no_early_result", res_valid, 1'b0);
        cmd_sub = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op_a = a1[i]; op_b = b1[i];
            step();
            check($sformatf("b2b_c1_s%0d", i), res_s, s1[i]);
            check($sformatf("b2b_c1_last%0d", i), res_last, (i == 3));
            check($sformatf("b2b_c1_cmd_ready%0d", i), cmd_ready, (i == 3));
        end
        check("b2b_c1_cout", res_cout, 1'b0);
        step();
        check("b2b_cmd2_taken", cmd_ready, 1'b0);
        check("b2b_gap_valid", res_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            op_a = a2[i]; op_b = b2[i];
            step();
            check($sformatf("b2b_c2_valid%0d", i), res_valid, 1'b1);
            check($sformatf("b2b_c2_s%0d", i), res_s, s2[i]);
            check($sformatf("b2b_c2_last%0d", i), res_last, (i == 3));
        end
        cmd_valid = 1'b0; op_valid = 1'b0;
        check("b2b_c2_cout", res_cout, 1'b1);
        check("b2b_c2_ovf", res_ovf, 1'b0);
        step();
        check("b2b_end_valid", res_valid, 1'b0);
        check("b2b_end_cmd_ready", cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
